alu_op_sequencer: RTL and testbench

//  Multi-cycle controller that time-shares the team's combinational 8-bit ALU to run
//  16-bit ADD/SUB/XOR and 8x8 unsigned shift-add MUL. Sits between a requester
//  (start/done handshake) and one ALU instance in the parent; owns all ALU select lines.

---
 rtl/alu_op_sequencer_pkg.sv | 34 +++
 rtl/alu_op_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer: op codes, ALU selects, FSM states.
package alu_op_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_ADD16 = 2'b00,
    OP_SUB16 = 2'b01,
    OP_MUL8  = 2'b10,
    OP_XOR16 = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_MUL,
    ST_DONE
  } state_e;

  localparam logic [2:0] SEL_PASS = 3'b000;
  localparam logic [2:0] SEL_ADD  = 3'b001;
  localparam logic [2:0] SEL_SUB  = 3'b010;
  localparam logic [2:0] SEL_XOR  = 3'b101;

  // ALU select used for both byte halves of ADD/SUB/XOR
  function automatic logic [2:0] op_sel(input op_e op);
    case (op)
      OP_ADD16: op_sel = SEL_ADD;
      OP_SUB16: op_sel = SEL_SUB;
      OP_XOR16: op_sel = SEL_XOR;
      default:  op_sel = SEL_PASS;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller time-sharing an external combinational DW-bit ALU to run
// 2*DW-bit ADD/SUB/XOR (two byte passes) and DWxDW unsigned shift-add MUL.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [2*DW-1:0] a_in,
  input  logic [2*DW-1:0] b_in,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] result,
  output logic            carry,
  output logic            zero,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [2:0]      alu_s,
  output logic            alu_cin,
  input  logic [DW-1:0]   alu_g,
  input  logic            alu_cout
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  state_e            state_q,  state_d;
  op_e               op_q,     op_d;
  logic [2*DW-1:0]   a_q,      a_d;
  logic [2*DW-1:0]   b_q,      b_d;
  logic [2*DW-1:0]   p_q,      p_d;
  logic [CW-1:0]     cnt_q,    cnt_d;
  logic [2*DW-1:0]   result_q, result_d;
  logic              carry_q,  carry_d;
  logic              zero_q,   zero_d;

  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;

  // Next-state, datapath updates and ALU drive for the current state
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    busy     = 1'b0;
    done     = 1'b0;
    alu_a    = '0;
    alu_b    = '0;
    alu_s    = SEL_PASS;
    alu_cin  = 1'b0;

    case (state_q)
      ST_LO: begin
        busy     = 1'b1;
        alu_a    = a_q[DW-1:0];
        alu_b    = b_q[DW-1:0];
        alu_s    = op_sel(op_q);
        alu_cin  = (op_q == OP_SUB16);
        result_d[DW-1:0] = alu_g;
        carry_d  = alu_cout;
        state_d  = ST_HI;
      end
      ST_HI: begin
        busy     = 1'b1;
        alu_a    = a_q[2*DW-1:DW];
        alu_b    = b_q[2*DW-1:DW];
        alu_s    = op_sel(op_q);
        alu_cin  = (op_q == OP_XOR16) ? 1'b0 : carry_q;
        result_d[2*DW-1:DW] = alu_g;
        carry_d  = (op_q == OP_XOR16) ? 1'b0 : alu_cout;
        zero_d   = ({alu_g, result_q[DW-1:0]} == '0);
        state_d  = ST_DONE;
      end
      ST_MUL: begin
        busy     = 1'b1;
        alu_a    = p_q[2*DW-1:DW];
        alu_b    = a_q[DW-1:0];
        alu_s    = p_q[0] ? SEL_ADD : SEL_PASS;
        p_d      = {alu_cout, alu_g, p_q[DW-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          result_d = p_d;
          carry_d  = 1'b0;
          zero_d   = (p_d == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Accept overrides the IDLE/DONE exit so a start in DONE runs back-to-back
    if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      op_d = op_e'(op);
      a_d  = a_in;
      b_d  = b_in;
      if (op_e'(op) == OP_MUL8) begin
        p_d     = {{DW{1'b0}}, b_in[DW-1:0]};
        cnt_d   = '0;
        state_d = ST_MUL;
      end else begin
        state_d = ST_LO;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD16;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a behavioural parent ALU.
module tb_alu_op_sequencer;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, XOR = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a_in, b_in;
  logic        busy, done;
  logic [15:0] result;
  logic        carry, zero;
  logic [7:0]  alu_a, alu_b, alu_g;
  logic [2:0]  alu_s;
  logic        alu_cin, alu_cout;

  int errors = 0;
  int checks = 0;

  alu_op_sequencer #(.DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_g(alu_g), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // Parent ALU: {s,cin} 000_0 pass, 001_c A+B+c, 010_c A+~B+c, 101_0 A^B
  always_comb begin
    case ({alu_s, alu_cin})
      4'b0010, 4'b0011: {alu_cout, alu_g} = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_cin};
      4'b0100, 4'b0101: {alu_cout, alu_g} = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'b0, alu_cin};
      4'b1010:          {alu_cout, alu_g} = {1'b0, alu_a ^ alu_b};
      default:          {alu_cout, alu_g} = {1'b0, alu_a};
    endcase
  end

  // Called mid-cycle; start is high for this cycle (cycle 0). Returns the cycle done
  // was seen (0 on timeout) and how many cycles busy was high before it.
  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       output int dcyc, output int bcnt);
    start = 1'b1; op = o; a_in = a; b_in = b;
    dcyc = 0; bcnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin dcyc = c; break; end
      if (busy) bcnt++;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = ADD; a_in = 16'hFFFF; b_in = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if ({busy, done, result, carry, zero} !== 19'h0) begin
      errors++; $display("FAIL reset_outs: busy=%b done=%b result=%h carry=%b zero=%b, want all 0",
                         busy, done, result, carry, zero);
    end
    checks++;
    if ({alu_a, alu_b, alu_s, alu_cin} !== 20'h0) begin
      errors++; $display("FAIL reset_alu: a=%h b=%h s=%b cin=%b, want all 0", alu_a, alu_b, alu_s, alu_cin);
    end
  endtask

  task automatic test_add();
    int d, b;
    idle_cycle();
    issue(ADD, 16'h00FF, 16'h0001, d, b);
    checks++; if (d !== 3) begin errors++; $display("FAIL add_lat: done cycle %0d, want 3", d); end
    checks++; if (b !== 2) begin errors++; $display("FAIL add_busy: busy cycles %0d, want 2", b); end
    checks++;
    if ({result, carry, zero} !== {16'h0100, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_00ff: result=%h c=%b z=%b, want 0100 0 0", result, carry, zero);
    end
    idle_cycle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: done=%b after DONE, want 0", done); end
    checks++; if (result !== 16'h0100) begin errors++; $display("FAIL result_hold: %h, want 0100", result); end
    issue(ADD, 16'hFFFF, 16'h0001, d, b);
    checks++;
    if ({result, carry, zero} !== {16'h0000, 1'b1, 1'b1} || d !== 3) begin
      errors++; $display("FAIL add_wrap: result=%h c=%b z=%b cyc=%0d, want 0000 1 1 3", result, carry, zero, d);
    end
  endtask

  task automatic test_sub_xor();
    int d, b;
    idle_cycle();
    issue(SUB, 16'h0100, 16'h0001, d, b);
    checks++;
    if ({result, carry, zero} !== {16'h00FF, 1'b1, 1'b0} || d !== 3) begin
      errors++; $display("FAIL sub_borrow_lo: result=%h c=%b z=%b cyc=%0d, want 00ff 1 0 3", result, carry, zero, d);
    end
    idle_cycle();
    issue(SUB, 16'h0000, 16'h0001, d, b);
    checks++;
    if ({result, carry, zero} !== {16'hFFFF, 1'b0, 1'b0} || d !== 3) begin
      errors++; $display("FAIL sub_under: result=%h c=%b z=%b cyc=%0d, want ffff 0 0 3", result, carry, zero, d);
    end
    idle_cycle();
    issue(XOR, 16'hA5A5, 16'hFFFF, d, b);
    checks++;
    if ({result, carry, zero} !== {16'h5A5A, 1'b0, 1'b0} || d !== 3) begin
      errors++; $display("FAIL xor: result=%h c=%b z=%b cyc=%0d, want 5a5a 0 0 3", result, carry, zero, d);
    end
  endtask

  task automatic test_mul();
    int d, b;
    idle_cycle();
    issue(MUL, 16'h00FF, 16'h00FF, d, b);
    checks++; if (d !== 9) begin errors++; $display("FAIL mul_lat: done cycle %0d, want 9", d); end
    checks++; if (b !== 8) begin errors++; $display("FAIL mul_busy: busy cycles %0d, want 8", b); end
    checks++;
    if ({result, carry, zero} !== {16'hFE01, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mul_ff: result=%h c=%b z=%b, want fe01 0 0", result, carry, zero);
    end
    idle_cycle();
    issue(MUL, 16'h0000, 16'h0037, d, b);
    checks++;
    if ({result, carry, zero} !== {16'h0000, 1'b0, 1'b1} || d !== 9) begin
      errors++; $display("FAIL mul_zero: result=%h c=%b z=%b cyc=%0d, want 0000 0 1 9", result, carry, zero, d);
    end
    idle_cycle();
    issue(MUL, 16'hAB12, 16'hCD34, d, b);
    checks++;
    if ({result, carry, zero} !== {16'h03A8, 1'b0, 1'b0} || d !== 9) begin
      errors++; $display("FAIL mul_lowbytes: result=%h c=%b z=%b cyc=%0d, want 03a8 0 0 9", result, carry, zero, d);
    end
  endtask

  task automatic test_start_while_busy();
    int d;
    idle_cycle();
    start = 1'b1; op = MUL; a_in = 16'h00FF; b_in = 16'h00FF; d = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      start = (c == 3);
      if (c == 3) begin op = XOR; a_in = 16'h1234; b_in = 16'h4321; end
      if (done) begin d = c; break; end
    end
    start = 1'b0;
    checks++;
    if (result !== 16'hFE01 || d !== 9) begin
      errors++; $display("FAIL busy_ignore: result=%h cyc=%0d, want fe01 9", result, d);
    end
  endtask

  task automatic test_back_to_back();
    int d, b;
    idle_cycle();
    issue(ADD, 16'h1234, 16'h1111, d, b);
    checks++;
    if (result !== 16'h2345 || d !== 3) begin
      errors++; $display("FAIL b2b_first: result=%h cyc=%0d, want 2345 3", result, d);
    end
    issue(SUB, 16'h5000, 16'h1000, d, b);
    checks++;
    if ({result, carry} !== {16'h4000, 1'b1} || d !== 3 || b !== 2) begin
      errors++; $display("FAIL b2b_second: result=%h c=%b cyc=%0d busy=%0d, want 4000 1 3 2", result, carry, d, b);
    end
  endtask

  task automatic test_reset_mid_mul();
    int d, b, seen;
    idle_cycle();
    start = 1'b1; op = MUL; a_in = 16'h005A; b_in = 16'h0077;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if ({busy, done, result, carry, zero, alu_a, alu_b, alu_s, alu_cin} !== 39'h0) begin
      errors++; $display("FAIL reset_mid_mul: busy=%b done=%b result=%h c=%b z=%b alu=%h/%h/%b/%b, want all 0",
                         busy, done, result, carry, zero, alu_a, alu_b, alu_s, alu_cin);
    end
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_no_done: %0d active cycles, want 0", seen); end
    issue(ADD, 16'h0001, 16'h0002, d, b);
    checks++;
    if ({result, carry, zero} !== {16'h0003, 1'b0, 1'b0} || d !== 3) begin
      errors++; $display("FAIL post_reset_add: result=%h c=%b z=%b cyc=%0d, want 0003 0 0 3", result, carry, zero, d);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_xor();
    test_mul();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
